// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: in-flight owner tags and pipe entries.
package mem_arb_pkg;

  localparam int unsigned MEM_LATENCY = 2;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
    logic   squash;
  } inflight_t;

endpackage

// File: rtl/mem_arb_inflight_pipe.sv
// Two-stage owner/squash shift register tracking accesses in flight to the memory port.
// A flush marks every fetch entry currently held so its response is dropped on return.
module mem_arb_inflight_pipe
  import mem_arb_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      en_i,
  input  logic      issue_i,
  input  owner_t    owner_i,
  input  logic      flush_i,
  output inflight_t head_o
);

  inflight_t s1_q, s1_d;
  inflight_t s2_q, s2_d;

  always_comb begin
    s1_d = s1_q;
    s2_d = s2_q;
    if (en_i) begin
      // The access issued this cycle belongs to the redirected stream, so it is never squashed.
      s1_d = '{valid: issue_i, owner: owner_i, squash: 1'b0};
      s2_d = s1_q;
      if (flush_i && s1_q.valid && (s1_q.owner == OWN_IF)) begin
        s2_d.squash = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign head_o = s2_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 2-cycle pipelined memory port between fetch and the data stage.
// Define ARB_STARVE_GUARD_EN to build in the fetch starvation guard.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clk_en_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_grant_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  input  logic [3:0]        d_be_i,
  output logic              d_grant_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_be_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  if (STARVE_MAX == 0) begin : g_starve_max_check
    $error("STARVE_MAX must be nonzero");
  end

  logic      active;
  logic      force_if;
  inflight_t head;

  assign active = rst_ni & clk_en_i;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

  logic [CntW-1:0] starve_q, starve_d;

  assign force_if = if_req_i && (starve_q == CntW'(STARVE_MAX));

  always_comb begin
    starve_d = starve_q;
    if (active) begin
      if (if_grant_o) begin
        starve_d = '0;
      end else if (if_req_i && d_grant_o) begin
        starve_d = starve_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  always_comb begin
    d_grant_o  = active & d_req_i & ~force_if;
    if_grant_o = active & if_req_i & (force_if | ~d_req_i);
  end

  always_comb begin
    mem_en_o    = if_grant_o | d_grant_o;
    mem_we_o    = d_grant_o & d_we_i;
    mem_addr_o  = d_grant_o ? d_addr_i : if_addr_i;
    mem_wdata_o = d_grant_o ? d_wdata_i : '0;
    mem_be_o    = d_grant_o ? d_be_i : 4'hF;
  end

  mem_arb_inflight_pipe u_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (clk_en_i),
    .issue_i (mem_en_o),
    .owner_i (d_grant_o ? OWN_D : OWN_IF),
    .flush_i (if_flush_i),
    .head_o  (head)
  );

  // A flush in the same cycle as a fetch return suppresses that return as well.
  assign if_rvalid_o = active & head.valid & (head.owner == OWN_IF) & ~head.squash & ~if_flush_i;
  assign d_rvalid_o  = active & head.valid & (head.owner == OWN_D);
  assign if_rdata_o  = mem_rdata_i;
  assign d_rdata_o   = mem_rdata_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a response scoreboard and a 2-cycle memory model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, clk_en;
  logic        if_req, if_flush;
  logic [31:0] if_addr;
  logic        if_grant, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        d_grant, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clk_en_i    (clk_en),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_flush_i  (if_flush),
    .if_grant_o  (if_grant),
    .if_rvalid_o (if_rvalid),
    .if_rdata_o  (if_rdata),
    .d_req_i     (d_req),
    .d_we_i      (d_we),
    .d_addr_i    (d_addr),
    .d_wdata_i   (d_wdata),
    .d_be_i      (d_be),
    .d_grant_o   (d_grant),
    .d_rvalid_o  (d_rvalid),
    .d_rdata_o   (d_rdata),
    .mem_en_o    (mem_en),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_be_o    (mem_be),
    .mem_rdata_i (mem_rdata)
  );

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory model: read data appears two enabled edges after issue, holds while clk_en is low.
  logic [31:0] m1_q, m2_q;
  always_ff @(posedge clk) begin
    if (clk_en) begin
      m1_q <= mem_en ? rd_fn(mem_addr) : 32'h0;
      m2_q <= m1_q;
    end
  end
  assign mem_rdata = m2_q;

  typedef struct {
    bit          own_d;
    logic [31:0] data;
    bit          chk;
    int          due;
  } exp_t;

  exp_t q[$];
  int   ecyc = 0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input bit exp_ifg, input bit exp_dg, input string tag);
    bit e_if, e_d, due_now;
    @(negedge clk);
    chk({tag, ".if_grant"}, 32'(if_grant), 32'(exp_ifg));
    chk({tag, ".d_grant"}, 32'(d_grant), 32'(exp_dg));
    chk({tag, ".mem_en"}, 32'(mem_en), 32'(exp_ifg | exp_dg));
    if (exp_dg) begin
      chk({tag, ".mem_addr"}, mem_addr, d_addr);
      chk({tag, ".mem_we"}, 32'(mem_we), 32'(d_we));
      chk({tag, ".mem_be"}, 32'(mem_be), 32'(d_be));
      if (d_we) chk({tag, ".mem_wdata"}, mem_wdata, d_wdata);
    end else if (exp_ifg) begin
      chk({tag, ".mem_addr"}, mem_addr, if_addr);
      chk({tag, ".mem_we"}, 32'(mem_we), 32'd0);
    end
    e_if    = 1'b0;
    e_d     = 1'b0;
    due_now = rst_n && clk_en && (q.size() > 0) && (q[0].due == ecyc);
    if (due_now) begin
      if (q[0].own_d) e_d = 1'b1;
      else            e_if = !if_flush;
    end
    chk({tag, ".if_rvalid"}, 32'(if_rvalid), 32'(e_if));
    chk({tag, ".d_rvalid"}, 32'(d_rvalid), 32'(e_d));
    if (e_if && q[0].chk) chk({tag, ".if_rdata"}, if_rdata, q[0].data);
    if (e_d && q[0].chk) chk({tag, ".d_rdata"}, d_rdata, q[0].data);
    if (due_now) void'(q.pop_front());
    if (!rst_n) begin
      q.delete();
    end else if (clk_en) begin
      if (if_flush) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
          if (!q[i].own_d) q.delete(i);
        end
      end
      if (exp_dg)       q.push_back('{1'b1, rd_fn(d_addr), !d_we, ecyc + 2});
      else if (exp_ifg) q.push_back('{1'b0, rd_fn(if_addr), 1'b1, ecyc + 2});
    end
    @(posedge clk);
    #1;
    if (rst_n && clk_en) ecyc++;
  endtask

  initial begin
    rst_n = 1'b0; clk_en = 1'b1;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = 4'h0;
    @(posedge clk); #1;
    // Reset holds grants and responses low even with requests pending.
    if_req = 1'b1; d_req = 1'b1;
    tick(0, 0, "reset");
    if_req = 1'b0; d_req = 1'b0; rst_n = 1'b1;
    tick(0, 0, "idle");

    // Fetch stream, one per cycle.
    if_req = 1'b1; if_addr = 32'h400; tick(1, 0, "fetch0");
    if_addr = 32'h404; tick(1, 0, "fetch1");
    if_addr = 32'h408; tick(1, 0, "fetch2");
    if_req = 1'b0;
    repeat (3) tick(0, 0, "fetch_drain");

    // Conflict: data wins.
    if_req = 1'b1; if_addr = 32'h500; d_req = 1'b1; d_addr = 32'h1000;
    tick(0, 1, "conflict");
    if_req = 1'b0; d_req = 1'b0;
    repeat (2) tick(0, 0, "conflict_drain");

    // Write with partial byte enables.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
    tick(0, 1, "write");
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
    repeat (2) tick(0, 0, "write_drain");

    // Mixed owners back to back.
    if_req = 1'b1; if_addr = 32'h600; tick(1, 0, "mix_f0");
    if_req = 1'b0; d_req = 1'b1; d_addr = 32'h3000; tick(0, 1, "mix_d");
    d_req = 1'b0; if_req = 1'b1; if_addr = 32'h604; tick(1, 0, "mix_f1");
    if_req = 1'b0;
    repeat (3) tick(0, 0, "mix_drain");

    // Flush squashes the older fetch; the one granted alongside the flush returns.
    if_req = 1'b1; if_addr = 32'h700; tick(1, 0, "flush_f0");
    if_addr = 32'h800; if_flush = 1'b1; tick(1, 0, "flush_f1");
    if_req = 1'b0; if_flush = 1'b0;
    repeat (3) tick(0, 0, "flush_drain");

    // Flush coinciding with a fetch return; a data read in flight is untouched.
    if_req = 1'b1; if_addr = 32'h900; tick(1, 0, "flush2_f");
    if_req = 1'b0; d_req = 1'b1; d_addr = 32'h3400; tick(0, 1, "flush2_d");
    d_req = 1'b0; if_flush = 1'b1; tick(0, 0, "flush2_same");
    if_flush = 1'b0;
    repeat (2) tick(0, 0, "flush2_drain");

    // clk_en low mid-flight delays responses without losing them.
    if_req = 1'b1; if_addr = 32'hA00; tick(1, 0, "ce_f");
    if_req = 1'b0; d_req = 1'b1; d_addr = 32'h4000; tick(0, 1, "ce_d");
    d_req = 1'b0; if_req = 1'b1; clk_en = 1'b0;
    repeat (3) tick(0, 0, "ce_stall");
    if_req = 1'b0; clk_en = 1'b1;
    repeat (3) tick(0, 0, "ce_drain");

    // Reset with two accesses in flight discards them.
    if_req = 1'b1; if_addr = 32'hB00; tick(1, 0, "rst_f");
    if_req = 1'b0; d_req = 1'b1; d_addr = 32'h5000; tick(0, 1, "rst_d");
    d_req = 1'b0; rst_n = 1'b0; tick(0, 0, "rst_mid");
    rst_n = 1'b1;
    repeat (3) tick(0, 0, "rst_after");

    // Both requesting continuously.
    if_req = 1'b1; if_addr = 32'hC00; d_req = 1'b1; d_addr = 32'h6000;
`ifdef ARB_STARVE_GUARD_EN
    for (int r = 0; r < 2; r++) begin
      repeat (4) tick(0, 1, "guard_d");
      tick(1, 0, "guard_f");
    end
`else
    repeat (10) tick(0, 1, "prio_d");
`endif
    if_req = 1'b0; d_req = 1'b0;
    repeat (3) tick(0, 0, "final_drain");

    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
